// File: rtl/ddr_dm_stats_monitor.sv
// Passive statistics and BTT-vs-beat-count checker for one AXI DataMover channel set.
// Optional define DM_STATS_SNAPSHOT_EN adds stats_snapshot and shadowed counter outputs.
module ddr_dm_stats_monitor #(
    parameter int DATA_WIDTH     = 512,
    parameter int CMD_FIFO_DEPTH = 16
) (
    input  logic        mem_clk,
    input  logic        mem_rst,
    input  logic        stats_clear,
`ifdef DM_STATS_SNAPSHOT_EN
    input  logic        stats_snapshot,
`endif
    input  logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [71:0] cmd_data,
    input  logic        data_valid,
    input  logic        data_ready,
    input  logic        data_last,
    input  logic        sts_valid,
    input  logic        sts_ready,
    input  logic [7:0]  sts_data,
    output logic [31:0] cmd_counter,
    output logic [31:0] word_counter,
    output logic [31:0] pkg_counter,
    output logic [47:0] length_counter,
    output logic [31:0] sts_counter,
    output logic [31:0] sts_error_counter,
    output logic        error,
    output logic [15:0] outstanding
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(DATA_BYTES);
    localparam int PTR_W      = $clog2(CMD_FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [23:0]      ROUND_UP   = 24'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(CMD_FIFO_DEPTH);

    // Number of stream beats needed to carry btt bytes (rounded up).
    function automatic logic [22:0] exp_beats(input logic [22:0] btt);
        logic [23:0] sum;
        sum = {1'b0, btt} + ROUND_UP;
        return 23'(sum >> BYTE_SHIFT);
    endfunction

    logic        cmd_hs_s;
    logic        beat_hs_s;
    logic        sts_hs_s;
    logic [22:0] btt_s;
    logic        btt_zero_s;
    logic        sts_bad_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        push_s;
    logic        pop_s;
    logic [22:0] head_s;
    logic        err_event_s;
    logic [15:0] out_next_s;

    logic [22:0]      fifo_mem_r [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] fifo_cnt_r;
    logic [22:0]      beat_cnt_r;

    logic [31:0] cmd_cnt_r;
    logic [31:0] word_cnt_r;
    logic [31:0] pkg_cnt_r;
    logic [47:0] len_cnt_r;
    logic [31:0] sts_cnt_r;
    logic [31:0] sts_err_cnt_r;
    logic [15:0] out_r;
    logic        error_r;

    // Address field and status tag carry no statistics.
    logic unused_bits_s;
    assign unused_bits_s = &{1'b0, cmd_data[71:23], sts_data[3:0]};

    assign cmd_hs_s     = cmd_valid & cmd_ready;
    assign beat_hs_s    = data_valid & data_ready;
    assign sts_hs_s     = sts_valid & sts_ready;
    assign btt_s        = cmd_data[22:0];
    assign btt_zero_s   = (btt_s == 23'd0);
    assign sts_bad_s    = ~sts_data[7] | (sts_data[6:4] != 3'b000);
    assign fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
    assign fifo_full_s  = (fifo_cnt_r == FULL_LEVEL);
    assign head_s       = fifo_mem_r[rd_ptr_r];

    // A same-cycle push never feeds an empty FIFO's pop; a pop frees a full slot for the push.
    assign pop_s  = beat_hs_s & data_last & ~fifo_empty_s;
    assign push_s = cmd_hs_s & ~btt_zero_s & (~fifo_full_s | pop_s);

    // Collect every condition that latches the sticky error this cycle.
    always_comb begin
        err_event_s = 1'b0;
        if (cmd_hs_s && btt_zero_s) begin
            err_event_s = 1'b1;
        end else if (cmd_hs_s && !push_s) begin
            err_event_s = 1'b1;
        end else begin
            err_event_s = 1'b0;
        end
        if (beat_hs_s && data_last && fifo_empty_s) begin
            err_event_s = 1'b1;
        end else if (pop_s && ((beat_cnt_r + 23'd1) != head_s)) begin
            err_event_s = 1'b1;
        end else begin
            err_event_s = err_event_s;
        end
        if (sts_hs_s && !cmd_hs_s && (out_r == 16'h0000)) begin
            err_event_s = 1'b1;
        end else begin
            err_event_s = err_event_s;
        end
    end

    // Saturating commands-in-flight count; simultaneous cmd and sts cancel out.
    always_comb begin
        out_next_s = out_r;
        if (cmd_hs_s && !sts_hs_s) begin
            if (out_r != 16'hFFFF) begin
                out_next_s = out_r + 16'd1;
            end else begin
                out_next_s = out_r;
            end
        end else if (sts_hs_s && !cmd_hs_s) begin
            if (out_r != 16'h0000) begin
                out_next_s = out_r - 16'd1;
            end else begin
                out_next_s = out_r;
            end
        end else begin
            out_next_s = out_r;
        end
    end

    // Expected-beats storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge mem_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= exp_beats(btt_s);
        end
    end

    // FIFO pointers, occupancy and in-packet beat count; stats_clear deliberately leaves these alone.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
            beat_cnt_r <= 23'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (beat_hs_s) begin
                beat_cnt_r <= data_last ? 23'd0 : beat_cnt_r + 23'd1;
            end
        end
    end

    // Live statistics counters and outstanding; clear drops the cycle's events.
    always_ff @(posedge mem_clk) begin
        if (mem_rst || stats_clear) begin
            cmd_cnt_r     <= 32'd0;
            word_cnt_r    <= 32'd0;
            pkg_cnt_r     <= 32'd0;
            len_cnt_r     <= 48'd0;
            sts_cnt_r     <= 32'd0;
            sts_err_cnt_r <= 32'd0;
            out_r         <= 16'd0;
        end else begin
            if (cmd_hs_s) begin
                cmd_cnt_r <= cmd_cnt_r + 32'd1;
                len_cnt_r <= len_cnt_r + {25'd0, btt_s};
            end
            if (beat_hs_s) begin
                word_cnt_r <= word_cnt_r + 32'd1;
            end
            if (beat_hs_s && data_last) begin
                pkg_cnt_r <= pkg_cnt_r + 32'd1;
            end
            if (sts_hs_s) begin
                sts_cnt_r <= sts_cnt_r + 32'd1;
            end
            if (sts_hs_s && sts_bad_s) begin
                sts_err_cnt_r <= sts_err_cnt_r + 32'd1;
            end
            out_r <= out_next_s;
        end
    end

    // Sticky error flag.
    always_ff @(posedge mem_clk) begin
        if (mem_rst || stats_clear) begin
            error_r <= 1'b0;
        end else if (err_event_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign error = error_r;

`ifdef DM_STATS_SNAPSHOT_EN
    logic [31:0] cmd_shd_r;
    logic [31:0] word_shd_r;
    logic [31:0] pkg_shd_r;
    logic [47:0] len_shd_r;
    logic [31:0] sts_shd_r;
    logic [31:0] sts_err_shd_r;
    logic [15:0] out_shd_r;

    // Shadow copy so software reads a coherent set of multi-word values.
    always_ff @(posedge mem_clk) begin
        if (mem_rst || stats_clear) begin
            cmd_shd_r     <= 32'd0;
            word_shd_r    <= 32'd0;
            pkg_shd_r     <= 32'd0;
            len_shd_r     <= 48'd0;
            sts_shd_r     <= 32'd0;
            sts_err_shd_r <= 32'd0;
            out_shd_r     <= 16'd0;
        end else if (stats_snapshot) begin
            cmd_shd_r     <= cmd_cnt_r;
            word_shd_r    <= word_cnt_r;
            pkg_shd_r     <= pkg_cnt_r;
            len_shd_r     <= len_cnt_r;
            sts_shd_r     <= sts_cnt_r;
            sts_err_shd_r <= sts_err_cnt_r;
            out_shd_r     <= out_r;
        end
    end

    assign cmd_counter       = cmd_shd_r;
    assign word_counter      = word_shd_r;
    assign pkg_counter       = pkg_shd_r;
    assign length_counter    = len_shd_r;
    assign sts_counter       = sts_shd_r;
    assign sts_error_counter = sts_err_shd_r;
    assign outstanding       = out_shd_r;
`else
    assign cmd_counter       = cmd_cnt_r;
    assign word_counter      = word_cnt_r;
    assign pkg_counter       = pkg_cnt_r;
    assign length_counter    = len_cnt_r;
    assign sts_counter       = sts_cnt_r;
    assign sts_error_counter = sts_err_cnt_r;
    assign outstanding       = out_r;
`endif

endmodule

// File: tb/tb_ddr_dm_stats_monitor.sv
// Self-checking bench for ddr_dm_stats_monitor: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours DM_STATS_SNAPSHOT_EN.
module tb_ddr_dm_stats_monitor;

    localparam int DEPTH = 16;
    localparam int BYTES = 64;

    logic        mem_clk = 1'b0;
    logic        mem_rst = 1'b1;
    logic        stats_clear = 1'b0;
    logic        stats_snapshot = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [71:0] cmd_data = 72'd0;
    logic        data_valid = 1'b0;
    logic        data_ready = 1'b0;
    logic        data_last = 1'b0;
    logic        sts_valid = 1'b0;
    logic        sts_ready = 1'b0;
    logic [7:0]  sts_data = 8'd0;
    logic [31:0] cmd_counter;
    logic [31:0] word_counter;
    logic [31:0] pkg_counter;
    logic [47:0] length_counter;
    logic [31:0] sts_counter;
    logic [31:0] sts_error_counter;
    logic        error;
    logic [15:0] outstanding;

    ddr_dm_stats_monitor #(.DATA_WIDTH(512), .CMD_FIFO_DEPTH(DEPTH)) dut (
        .mem_clk(mem_clk),
        .mem_rst(mem_rst),
        .stats_clear(stats_clear),
`ifdef DM_STATS_SNAPSHOT_EN
        .stats_snapshot(stats_snapshot),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_last(data_last),
        .sts_valid(sts_valid),
        .sts_ready(sts_ready),
        .sts_data(sts_data),
        .cmd_counter(cmd_counter),
        .word_counter(word_counter),
        .pkg_counter(pkg_counter),
        .length_counter(length_counter),
        .sts_counter(sts_counter),
        .sts_error_counter(sts_error_counter),
        .error(error),
        .outstanding(outstanding)
    );

    always #5 mem_clk = ~mem_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: plain counts, a queue of expected packet lengths.
    longint unsigned m_cmd, m_word, m_pkg, m_len, m_sts, m_serr, m_out;
    longint unsigned s_cmd, s_word, s_pkg, s_len, s_sts, s_serr, s_out;
    bit              m_err;
    int              m_beats;
    int unsigned     exp_q[$];

    task automatic model_reset();
        m_cmd = 0; m_word = 0; m_pkg = 0; m_len = 0; m_sts = 0; m_serr = 0; m_out = 0;
        s_cmd = 0; s_word = 0; s_pkg = 0; s_len = 0; s_sts = 0; s_serr = 0; s_out = 0;
        m_err = 1'b0;
        m_beats = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit c, b, s, ev;
        int unsigned btt, head;
        if (mem_rst) begin
            model_reset();
            return;
        end
        c = cmd_valid && cmd_ready;
        b = data_valid && data_ready;
        s = sts_valid && sts_ready;
        btt = cmd_data[22:0];
        ev = 1'b0;
        if (b && data_last) begin
            if (exp_q.size() == 0) ev = 1'b1;
            else begin
                head = exp_q.pop_front();
                if (m_beats + 1 != head) ev = 1'b1;
            end
            m_beats = 0;
        end else if (b) begin
            m_beats++;
        end
        if (c) begin
            if (btt == 0) ev = 1'b1;
            else if (exp_q.size() >= DEPTH) ev = 1'b1;
            else exp_q.push_back((btt + BYTES - 1) / BYTES);
        end
        if (s && !c && m_out == 0) ev = 1'b1;
        if (stats_clear) begin
            m_cmd = 0; m_word = 0; m_pkg = 0; m_len = 0; m_sts = 0; m_serr = 0; m_out = 0;
            s_cmd = 0; s_word = 0; s_pkg = 0; s_len = 0; s_sts = 0; s_serr = 0; s_out = 0;
            m_err = 1'b0;
        end else begin
            if (stats_snapshot) begin
                s_cmd = m_cmd; s_word = m_word; s_pkg = m_pkg; s_len = m_len;
                s_sts = m_sts; s_serr = m_serr; s_out = m_out;
            end
            if (c) begin
                m_cmd = (m_cmd + 1) % (64'd1 << 32);
                m_len = (m_len + btt) % (64'd1 << 48);
            end
            if (b) m_word = (m_word + 1) % (64'd1 << 32);
            if (b && data_last) m_pkg = (m_pkg + 1) % (64'd1 << 32);
            if (s) m_sts = (m_sts + 1) % (64'd1 << 32);
            if (s && (!sts_data[7] || sts_data[6:4] != 3'b000)) m_serr = (m_serr + 1) % (64'd1 << 32);
            if (c && !s && m_out < 65535) m_out++;
            else if (s && !c && m_out > 0) m_out--;
            if (ev) m_err = 1'b1;
        end
    endtask

    task automatic compare_all();
`ifdef DM_STATS_SNAPSHOT_EN
        check_val("cmd_counter", 64'(cmd_counter), s_cmd);
        check_val("word_counter", 64'(word_counter), s_word);
        check_val("pkg_counter", 64'(pkg_counter), s_pkg);
        check_val("length_counter", 64'(length_counter), s_len);
        check_val("sts_counter", 64'(sts_counter), s_sts);
        check_val("sts_error_counter", 64'(sts_error_counter), s_serr);
        check_val("outstanding", 64'(outstanding), s_out);
`else
        check_val("cmd_counter", 64'(cmd_counter), m_cmd);
        check_val("word_counter", 64'(word_counter), m_word);
        check_val("pkg_counter", 64'(pkg_counter), m_pkg);
        check_val("length_counter", 64'(length_counter), m_len);
        check_val("sts_counter", 64'(sts_counter), m_sts);
        check_val("sts_error_counter", 64'(sts_error_counter), m_serr);
        check_val("outstanding", 64'(outstanding), m_out);
`endif
        check_val("error", 64'(error), 64'(m_err));
    endtask

    task automatic step();
        @(posedge mem_clk);
        model_step();
        @(negedge mem_clk);
        compare_all();
    endtask

    task automatic idle();
        mem_rst = 1'b0; stats_clear = 1'b0; stats_snapshot = 1'b0;
        cmd_valid = 1'b0; cmd_ready = 1'b0; cmd_data = 72'd0;
        data_valid = 1'b0; data_ready = 1'b0; data_last = 1'b0;
        sts_valid = 1'b0; sts_ready = 1'b0; sts_data = 8'd0;
    endtask

    task automatic do_reset();
        idle(); mem_rst = 1'b1; step(); step(); mem_rst = 1'b0;
    endtask

    task automatic send_cmd(input logic [22:0] btt);
        idle(); cmd_valid = 1'b1; cmd_ready = 1'b1; cmd_data = {49'd0, btt}; step();
    endtask

    task automatic send_beat(input logic last);
        idle(); data_valid = 1'b1; data_ready = 1'b1; data_last = last; step();
    endtask

    task automatic send_sts(input logic [7:0] d);
        idle(); sts_valid = 1'b1; sts_ready = 1'b1; sts_data = d; step();
    endtask

    // Makes the shadowed outputs (if present) show live values; plain idle cycle otherwise.
    task automatic snap_cycle();
        idle();
`ifdef DM_STATS_SNAPSHOT_EN
        stats_snapshot = 1'b1;
`endif
        step();
        idle();
    endtask

    initial begin
        model_reset();
        do_reset();
        check_val("rst_cmd", 64'(cmd_counter), 64'd0);
        check_val("rst_len", 64'(length_counter), 64'd0);
        check_val("rst_out", 64'(outstanding), 64'd0);
        check_val("rst_err", 64'(error), 64'd0);

        // Well-formed traffic: three commands, matching packets, OKAY status.
        send_cmd(23'd64); send_cmd(23'd128); send_cmd(23'd100);
        send_beat(1'b1);
        send_beat(1'b0); send_beat(1'b1);
        send_beat(1'b0); send_beat(1'b1);
        send_sts(8'h80); send_sts(8'h80); send_sts(8'h80);
        snap_cycle();
        check_val("tp1_cmd", 64'(cmd_counter), 64'd3);
        check_val("tp1_len", 64'(length_counter), 64'd292);
        check_val("tp1_word", 64'(word_counter), 64'd5);
        check_val("tp1_pkg", 64'(pkg_counter), 64'd3);
        check_val("tp1_sts", 64'(sts_counter), 64'd3);
        check_val("tp1_serr", 64'(sts_error_counter), 64'd0);
        check_val("tp1_out", 64'(outstanding), 64'd0);
        check_val("tp1_err", 64'(error), 64'd0);

        // Packet longer than its command.
        do_reset();
        send_cmd(23'd128); send_beat(1'b0); send_beat(1'b0);
        check_val("len_err_pre", 64'(error), 64'd0);
        send_beat(1'b1);
        check_val("len_err_post", 64'(error), 64'd1);
        snap_cycle();
        check_val("len_word", 64'(word_counter), 64'd3);
        check_val("len_pkg", 64'(pkg_counter), 64'd1);

        // Error status, then status with nothing outstanding.
        do_reset();
        send_cmd(23'd64); send_sts(8'hC0);
        snap_cycle();
        check_val("sts_serr", 64'(sts_error_counter), 64'd1);
        check_val("sts_out", 64'(outstanding), 64'd0);
        check_val("sts_err_pre", 64'(error), 64'd0);
        send_sts(8'h80);
        snap_cycle();
        check_val("underflow_err", 64'(error), 64'd1);
        check_val("underflow_out", 64'(outstanding), 64'd0);

        // FIFO overflow, then drain: no further mismatch and the FIFO ends empty.
        do_reset();
        for (int i = 0; i < 17; i++) send_cmd(23'd64);
        snap_cycle();
        check_val("ovf_cmd", 64'(cmd_counter), 64'd17);
        check_val("ovf_err", 64'(error), 64'd1);
        idle(); stats_clear = 1'b1; step(); idle();
        for (int i = 0; i < 16; i++) send_beat(1'b1);
        check_val("drain_err", 64'(error), 64'd0);
        send_beat(1'b1);
        check_val("empty_err", 64'(error), 64'd1);

        // stats_clear coinciding with cmd and beat handshakes.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_cmd(23'd64); send_beat(1'b1);
        end
        snap_cycle();
        check_val("pre_clr_cmd", 64'(cmd_counter), 64'd5);
        check_val("pre_clr_word", 64'(word_counter), 64'd5);
        idle(); stats_clear = 1'b1;
        cmd_valid = 1'b1; cmd_ready = 1'b1; cmd_data = {49'd0, 23'd128};
        data_valid = 1'b1; data_ready = 1'b1;
        step(); idle();
        check_val("clr_cmd", 64'(cmd_counter), 64'd0);
        check_val("clr_word", 64'(word_counter), 64'd0);
        check_val("clr_len", 64'(length_counter), 64'd0);
        check_val("clr_err", 64'(error), 64'd0);
        send_beat(1'b1);
        check_val("clr_pkt_ok", 64'(error), 64'd0);

        // 32-bit carry of length_counter, held by the shadow until the next snapshot.
        do_reset();
        for (int i = 0; i < 512; i++) send_cmd(23'h7FFFFF);
        send_cmd(23'd511);
        snap_cycle();
        check_val("len_ffff", 64'(length_counter), 64'h0000_FFFF_FFFF);
        send_cmd(23'd64);
`ifdef DM_STATS_SNAPSHOT_EN
        check_val("snap_hold0", 64'(length_counter), 64'h0000_FFFF_FFFF);
        idle(); step();
        check_val("snap_hold1", 64'(length_counter), 64'h0000_FFFF_FFFF);
        snap_cycle();
`endif
        check_val("len_carry", 64'(length_counter), 64'h0001_0000_003F);

        // Randomized traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            int unsigned r;
            idle();
            mem_rst = ($urandom_range(0, 499) == 0);
            stats_clear = ($urandom_range(0, 199) == 0);
            stats_snapshot = ($urandom_range(0, 15) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r == 0) cmd_data = {49'd0, 23'd0};
            else if (r == 1) cmd_data = {49'd0, 23'($urandom_range(1, 8388607))};
            else cmd_data = {49'd0, 23'($urandom_range(1, 256))};
            data_valid = ($urandom_range(0, 1) == 0);
            data_ready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() > 0 && m_beats + 1 >= exp_q[0])
                data_last = ($urandom_range(0, 9) != 0);
            else
                data_last = ($urandom_range(0, 19) == 0);
            sts_valid = ($urandom_range(0, 4) == 0);
            sts_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) sts_data = 8'($urandom_range(0, 255));
            else sts_data = {4'h8, 4'($urandom_range(0, 15))};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
